multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences a shared-ALU, shared-memory multicycle RV32I datapath: one instruction over 3–5 states.
- Replaces the single-cycle control path for the multicycle core variant.
- Drives PC/IR write enables, mux selects, the memory strobe and ALU control.
- Stalls on a memory ready handshake.

Parameters:
- none. All encodings are fixed in the shared package.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces state FETCH.
- op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU result == 0
- ALUR31  in  1  ALU result bit 31 (sign of rs1-rs2)
- mem_ready  in  1  memory completes access this cycle
- PCWrite  out  1  PC register load enable
- AdrSrc  out  1  memory address: 0=PC, 1=Result
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  IR/OldPC load enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1
- ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=constant 4
- ImmSrc  out  2  00=I, 01=S, 10=B, 11=J (decoded combinationally from op, every state)
- AluControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- instr_done  out  1  1-cycle pulse in the final state of each instruction
- illegal  out  1  1-cycle pulse when DECODE sees an unsupported opcode

Behaviour:
- States (4-bit): FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB.
- All outputs are functions of state, plus op/funct/flags where noted. Unlisted strobes are 0; unlisted selects are 00.
- aluOp: 00 = add, 01 = sub, 10 = funct decode.
- funct decode:
  - funct3 000: sub if op[5] & funct7b5, else add.
  - 010 slt, 100 xor, 110 or, 111 and, others add.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, aluOp=00, ResultSrc=10.
  - PCWrite=IRWrite=mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (ALUOut=OldPC+imm). Next state by op:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - else: illegal=1, → FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. → MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds while !mem_ready, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. → FETCH.
- MEMWRITE:
  - AdrSrc=1, ResultSrc=00, MemWrite=1 held until mem_ready.
  - instr_done=mem_ready.
  - → FETCH on mem_ready.
- EXECR: ALUSrcA=10, ALUSrcB=00, aluOp=10. → ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, aluOp=10. → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. → FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, instr_done=1.
  - PCWrite=taken, where taken is:
    - funct3 000: Zero
    - 001: !Zero
    - 100: ALUR31
    - 101: !ALUR31
    - other funct3: 0.
  - → FETCH.
- JAL: ResultSrc=00, PCWrite=1, ALUSrcA=01, ALUSrcB=10, add (ALUOut=OldPC+4). → ALUWB.
- JALR: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1. → JALRWB.
- JALRWB: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1, instr_done=1. → FETCH.
- Reset:
  - Asynchronous; state=FETCH immediately, including mid-instruction.
  - PCWrite, IRWrite, MemWrite and RegWrite are gated to 0 while reset is high.
  - After release, outputs equal FETCH decode.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- No state persists between instructions besides the state register.
- Unused state encodings → FETCH, with all strobes 0.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state enum
  - opcode constants
  - AluControl codes
  - ImmSrc, ResultSrc, ALUSrcA and ALUSrcB encodings.
- Sub-module: reuse the existing alu_decoder for the aluOp/funct3/funct7b5 → AluControl mapping.
- FSM and branch condition live in this module.

Test Plan:
- lw (op 0000011), mem_ready low for 2 cycles in FETCH and 3 in MEMREAD:
  - Sequence FETCH×3, DECODE, MEMADR, MEMREAD×4, MEMWB.
  - PCWrite/IRWrite high only on the 3rd FETCH cycle.
  - RegWrite with ResultSrc=01 in MEMWB.
- add/sub R-type with funct7b5=0/1, mem_ready=1:
  - 4 cycles.
  - EXECR AluControl 000 then 001.
  - ALUWB RegWrite=1, instr_done pulse.
- Branches, BRANCH state:
  - beq, Zero=1 → PCWrite=1; bne, Zero=1 → PCWrite=0.
  - blt, ALUR31=1 → 1; bge, ALUR31=1 → 0.
  - funct3 010 → 0.
- jal, then jalr:
  - jal: JAL PCWrite=1 ResultSrc=00, then ALUWB RegWrite=1.
  - jalr: JALR PCWrite=1 ResultSrc=10, then JALRWB RegWrite=1; 4 cycles each after FETCH.
- op 1111111 → illegal pulses in DECODE, next state FETCH, no RegWrite/MemWrite.
- sw with mem_ready=0, reset asserted in MEMWRITE:
  - MemWrite drops in the same cycle; FETCH is entered asynchronously.
  - After release: FETCH outputs, AdrSrc=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared encodings for the multicycle RV32I control path
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRWB   = 4'd12
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps aluOp/funct3/funct7b5 onto the ALU control code
module alu_decoder
  import rv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Immediate forms never subtract: funct7b5 is part of the immediate there.
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b100:  alu_control_o = ALU_XOR;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing the multicycle RV32I datapath
module multicycle_controller
  import rv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] AluControl,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write, ir_write, mem_write, reg_write;

  function automatic logic branch_taken(input logic [2:0] f3, input logic zero, input logic neg);
    case (f3)
      3'b000:  return zero;
      3'b001:  return ~zero;
      3'b100:  return neg;
      3'b101:  return ~neg;
      default: return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        state_d    = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        alu_op     = ALUOP_SUB;
        pc_write   = branch_taken(funct3, Zero, ALUR31);
        instr_done = 1'b1;
      end
      S_JAL: begin
        // Jump target was formed in DECODE; the ALU now builds the link value.
        pc_write = 1'b1;
        ALUSrcA  = SRCA_OLDPC;
        ALUSrcB  = SRCB_FOUR;
        state_d  = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_write  = 1'b1;
        state_d   = S_JALRWB;
      end
      S_JALRWB: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (AluControl)
  );

  assign ImmSrc = imm_src_of(op);

  // Architectural write strobes must stay quiet for the whole reset pulse.
  assign PCWrite  = pc_write  & ~reset;
  assign IRWrite  = ir_write  & ~reset;
  assign MemWrite = mem_write & ~reset;
  assign RegWrite = reg_write & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, ALUR31, mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] AluControl;
  logic       instr_done, illegal;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ALUR31(ALUR31), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .AluControl(AluControl), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, adr, memw, irw, regw;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
    logic       done, ill;
  } ctrl_t;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011,
                         ITYPE = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111;

  localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4,
                 ST_MEMWRITE = 5, ST_EXECR = 6, ST_EXECI = 7, ST_ALUWB = 8, ST_BRANCH = 9,
                 ST_JAL = 10, ST_JALR = 11, ST_JALRWB = 12;

  ctrl_t act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ImmSrc, AluControl, instr_done, illegal};

  ctrl_t exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic is_legal(input logic [6:0] o);
    return o == LOAD || o == STORE || o == RTYPE || o == ITYPE ||
           o == BRANCH || o == JAL || o == JALR;
  endfunction

  function automatic logic [1:0] imm_model(input logic [6:0] o);
    if (o == STORE)  return 2'b01;
    if (o == BRANCH) return 2'b10;
    if (o == JAL)    return 2'b11;
    return 2'b00;
  endfunction

  // Arithmetic meaning of the R/I-type funct fields, as an ALU opcode.
  function automatic logic [2:0] funct_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic taken_model(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t model(input int step, input logic [6:0] o, input logic [2:0] f3,
                                  input logic f7, input logic z, input logic n, input logic mr);
    ctrl_t c;
    c = '0;
    c.imm = imm_model(o);
    case (step)
      ST_FETCH:    begin c.pcw = mr; c.irw = mr; c.sb = 2'b10; c.res = 2'b10; end
      ST_DECODE:   begin c.sa = 2'b01; c.sb = 2'b01; c.ill = !is_legal(o); end
      ST_MEMADR:   begin c.sa = 2'b10; c.sb = 2'b01; end
      ST_MEMREAD:  c.adr = 1'b1;
      ST_MEMWB:    begin c.res = 2'b01; c.regw = 1'b1; c.done = 1'b1; end
      ST_MEMWRITE: begin c.adr = 1'b1; c.memw = 1'b1; c.done = mr; end
      ST_EXECR:    begin c.sa = 2'b10; c.alu = funct_alu(o, f3, f7); end
      ST_EXECI:    begin c.sa = 2'b10; c.sb = 2'b01; c.alu = funct_alu(o, f3, f7); end
      ST_ALUWB:    begin c.regw = 1'b1; c.done = 1'b1; end
      ST_BRANCH:   begin c.sa = 2'b10; c.alu = 3'b001; c.done = 1'b1; c.pcw = taken_model(f3, z, n); end
      ST_JAL:      begin c.pcw = 1'b1; c.sa = 2'b01; c.sb = 2'b10; end
      ST_JALR:     begin c.sa = 2'b10; c.sb = 2'b01; c.res = 2'b10; c.pcw = 1'b1; end
      ST_JALRWB:   begin c.sa = 2'b01; c.sb = 2'b10; c.res = 2'b10; c.regw = 1'b1; c.done = 1'b1; end
      default:     c = '0;
    endcase
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // One clock period: drive the inputs just after the edge, queue the expected outputs.
  task automatic do_cycle(input int step, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input logic z, input logic n, input logic mr);
    @(posedge clk);
    #1;
    op = o; funct3 = f3; funct7b5 = f7; Zero = z; ALUR31 = n; mem_ready = mr;
    exp_q.push_back(model(step, o, f3, f7, z, n, mr));
    name_q.push_back($sformatf("step%0d_op%b_f3%b", step, o, f3));
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic n, input int wf, input int wm);
    for (int i = 0; i < wf; i++) do_cycle(ST_FETCH, o, f3, f7, z, n, 1'b0);
    do_cycle(ST_FETCH, o, f3, f7, z, n, 1'b1);
    do_cycle(ST_DECODE, o, f3, f7, z, n, rb());
    if (o == LOAD) begin
      do_cycle(ST_MEMADR, o, f3, f7, z, n, rb());
      for (int i = 0; i < wm; i++) do_cycle(ST_MEMREAD, o, f3, f7, z, n, 1'b0);
      do_cycle(ST_MEMREAD, o, f3, f7, z, n, 1'b1);
      do_cycle(ST_MEMWB, o, f3, f7, z, n, rb());
    end else if (o == STORE) begin
      do_cycle(ST_MEMADR, o, f3, f7, z, n, rb());
      for (int i = 0; i < wm; i++) do_cycle(ST_MEMWRITE, o, f3, f7, z, n, 1'b0);
      do_cycle(ST_MEMWRITE, o, f3, f7, z, n, 1'b1);
    end else if (o == RTYPE) begin
      do_cycle(ST_EXECR, o, f3, f7, z, n, rb());
      do_cycle(ST_ALUWB, o, f3, f7, z, n, rb());
    end else if (o == ITYPE) begin
      do_cycle(ST_EXECI, o, f3, f7, z, n, rb());
      do_cycle(ST_ALUWB, o, f3, f7, z, n, rb());
    end else if (o == BRANCH) begin
      do_cycle(ST_BRANCH, o, f3, f7, z, n, rb());
    end else if (o == JAL) begin
      do_cycle(ST_JAL, o, f3, f7, z, n, rb());
      do_cycle(ST_ALUWB, o, f3, f7, z, n, rb());
    end else if (o == JALR) begin
      do_cycle(ST_JALR, o, f3, f7, z, n, rb());
      do_cycle(ST_JALRWB, o, f3, f7, z, n, rb());
    end
  endtask

  initial begin : monitor
    ctrl_t e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %b expected %b", nm, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: stimulus did not complete in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [6:0] o;
    logic [6:0] pick [8];
    reset = 1'b1; op = LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
    Zero = 1'b0; ALUR31 = 1'b0; mem_ready = 1'b1;
    #12;
    chk("reset_pcwrite", 32'(PCWrite), 32'd0);
    chk("reset_irwrite", 32'(IRWrite), 32'd0);
    chk("reset_alusrcb", 32'(ALUSrcB), 32'd2);
    @(posedge clk); #1;
    mem_ready = 1'b0; reset = 1'b0; #1;
    chk("post_reset_fetch", 32'(act), 32'(model(ST_FETCH, LOAD, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0)));

    run_instr(LOAD, 3'b010, 1'b0, rb(), rb(), 2, 3);
    run_instr(RTYPE, 3'b000, 1'b0, rb(), rb(), 0, 0);
    run_instr(RTYPE, 3'b000, 1'b1, rb(), rb(), 0, 0);
    run_instr(BRANCH, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr(BRANCH, 3'b001, 1'b0, 1'b1, 1'b0, 0, 0);
    run_instr(BRANCH, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0);
    run_instr(BRANCH, 3'b101, 1'b0, 1'b0, 1'b1, 0, 0);
    run_instr(BRANCH, 3'b010, 1'b0, 1'b1, 1'b1, 0, 0);
    run_instr(JAL, 3'b000, 1'b0, rb(), rb(), 0, 0);
    run_instr(JALR, 3'b000, 1'b0, rb(), rb(), 0, 0);
    run_instr(7'b1111111, 3'b000, 1'b0, rb(), rb(), 0, 0);

    // Store stalled on memory, then reset arrives mid-write.
    do_cycle(ST_FETCH, STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    do_cycle(ST_DECODE, STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(ST_MEMADR, STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(ST_MEMWRITE, STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    do_cycle(ST_MEMWRITE, STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("sw_memwrite_before_reset", 32'(MemWrite), 32'd1);
    mem_ready = 1'b1; reset = 1'b1; #1;
    chk("sw_reset_memwrite", 32'(MemWrite), 32'd0);
    chk("sw_reset_adrsrc", 32'(AdrSrc), 32'd0);
    chk("sw_reset_pcwrite", 32'(PCWrite), 32'd0);
    chk("sw_reset_irwrite", 32'(IRWrite), 32'd0);
    chk("sw_reset_done", 32'(instr_done), 32'd0);
    @(posedge clk); #1;
    chk("sw_reset_held_pcwrite", 32'(PCWrite), 32'd0);
    mem_ready = 1'b0; reset = 1'b0; #1;
    chk("sw_after_release", 32'(act), 32'(model(ST_FETCH, STORE, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0)));

    pick = '{LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL, JALR, 7'b0000000};
    for (int k = 0; k < 200; k++) begin
      o = pick[$urandom_range(0, 7)];
      if (o == 7'b0000000) begin
        do o = 7'($urandom); while (is_legal(o));
      end
      run_instr(o, 3'($urandom), rb(), rb(), rb(),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
